// File: rtl/dds_pkg.sv
// Shared definitions for the DDS datapath and its sweep scheduler.
package dds_pkg;

    localparam int DDS_N  = 8;
    localparam int DDS_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_counter.sv
// Loadable down-counter that times how long each sweep frequency is held.
module dwell_counter
    import dds_pkg::*;
#(
    parameter int DW = DDS_DW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [DW-1:0] r_cnt;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= {DW{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {DW{1'b0}})) begin
            r_cnt <= r_cnt - {{(DW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {DW{1'b0}});

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS tuning word from start to stop
// with a programmable dwell, single-shot or looping, muted when idle.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int N  = DDS_N,
    parameter int DW = DDS_DW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_loop_en,
    input  logic [N:0]    i_f_start,
    input  logic [N:0]    i_f_stop,
    input  logic [N:0]    i_f_step,
    input  logic [DW-1:0] i_dwell,
    input  logic [N:0]    i_phase_cfg,
    input  logic [N:0]    i_amp_cfg,
    output logic [N:0]    o_freq_out,
    output logic [N:0]    o_phase_out,
    output logic [N:0]    o_amp_out,
    output logic          o_busy,
    output logic          o_done
);

    state_t        r_state, w_state_nxt;
    logic [N:0]    r_freq, r_phase, r_amp;
    logic          r_busy, r_done;
    logic [N:0]    r_f_start, r_f_stop, r_f_step;
    logic [DW-1:0] r_dwell;
    logic          r_loop_en;

    logic [N:0]    w_freq_nxt, w_phase_nxt, w_amp_nxt;
    logic          w_busy_nxt, w_done_nxt;
    logic          w_latch, w_load, w_en, w_zero;
    logic [DW-1:0] w_load_val;
    logic [N+1:0]  w_sum;

    // A dwell of 0 is treated as 1, so the reload value saturates at 0.
    function automatic logic [DW-1:0] f_reload(input logic [DW-1:0] d);
        return (d == {DW{1'b0}}) ? {DW{1'b0}} : (d - {{(DW-1){1'b0}}, 1'b1});
    endfunction

    assign w_sum = {1'b0, r_freq} + {1'b0, r_f_step};

    dwell_counter #(.DW(DW)) u_dwell (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    // Next-state and next-output decode; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_phase_nxt = r_phase;
        w_amp_nxt   = r_amp;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_load_val  = f_reload(r_dwell);
        case (r_state)
            IDLE: begin
                w_freq_nxt  = {(N+1){1'b0}};
                w_phase_nxt = {(N+1){1'b0}};
                w_amp_nxt   = {(N+1){1'b0}};
                w_busy_nxt  = 1'b0;
                if (i_start) begin
                    w_state_nxt = SWEEP;
                    w_freq_nxt  = i_f_start;
                    w_phase_nxt = i_phase_cfg;
                    w_amp_nxt   = i_amp_cfg;
                    w_busy_nxt  = 1'b1;
                    w_latch     = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = f_reload(i_dwell);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SWEEP: begin
                w_busy_nxt = 1'b1;
                if (!w_zero) begin
                    w_en = 1'b1;
                end else if (w_sum <= {1'b0, r_f_stop}) begin
                    w_freq_nxt = w_sum[N:0];
                    w_load     = 1'b1;
                end else if (r_loop_en) begin
                    w_freq_nxt = r_f_start;
                    w_load     = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_amp_nxt   = {(N+1){1'b0}};
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_freq_nxt  = {(N+1){1'b0}};
                w_phase_nxt = {(N+1){1'b0}};
                w_amp_nxt   = {(N+1){1'b0}};
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_freq_nxt  = {(N+1){1'b0}};
                w_phase_nxt = {(N+1){1'b0}};
                w_amp_nxt   = {(N+1){1'b0}};
                w_busy_nxt  = 1'b0;
            end
        endcase
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_freq_nxt  = {(N+1){1'b0}};
            w_phase_nxt = {(N+1){1'b0}};
            w_amp_nxt   = {(N+1){1'b0}};
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_latch     = 1'b0;
            w_load      = 1'b0;
            w_en        = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_freq  <= {(N+1){1'b0}};
            r_phase <= {(N+1){1'b0}};
            r_amp   <= {(N+1){1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
            r_phase <= w_phase_nxt;
            r_amp   <= w_amp_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Descriptor is captured only on an accepted start.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_f_start <= {(N+1){1'b0}};
            r_f_stop  <= {(N+1){1'b0}};
            r_f_step  <= {(N+1){1'b0}};
            r_dwell   <= {DW{1'b0}};
            r_loop_en <= 1'b0;
        end else if (w_latch) begin
            r_f_start <= i_f_start;
            r_f_stop  <= i_f_stop;
            r_f_step  <= i_f_step;
            r_dwell   <= i_dwell;
            r_loop_en <= i_loop_en;
        end else begin
            r_f_start <= r_f_start;
            r_f_stop  <= r_f_stop;
            r_f_step  <= r_f_step;
            r_dwell   <= r_dwell;
            r_loop_en <= r_loop_en;
        end
    end

    assign o_freq_out  = r_freq;
    assign o_phase_out = r_phase;
    assign o_amp_out   = r_amp;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
